mouse_packet_tracker: RTL and testbench

//  Assembles 3-byte PS/2 mouse stream packets from the PS/2 byte receiver into absolute

---
 rtl/mouse_pkg.sv | 38 +++
 rtl/mouse_packet_tracker_if.sv | 20 ++
 rtl/axis_clamp.sv | 37 +++
 rtl/mouse_packet_tracker.sv | 157 +++++++++++++++
 tb/tb_mouse_packet_tracker.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet tracker: FSM encoding,
// byte0 bit positions and the latched byte0 field layout.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_t;

  localparam int SYNC_BIT  = 3;
  localparam int XSIGN_BIT = 4;
  localparam int YSIGN_BIT = 5;
  localparam int XOVF_BIT  = 6;
  localparam int YOVF_BIT  = 7;

  // Only the byte0 fields that matter after it has been accepted.
  typedef struct packed {
    logic       yovf;
    logic       xovf;
    logic       ysign;
    logic       xsign;
    logic [2:0] btn;
  } b0_t;

  // Signed 9-bit movement; an overflowed axis contributes no movement.
  function automatic logic [8:0] make_delta(input logic sign, input logic ovf,
                                            input logic [7:0] mag);
    logic [8:0] d;
    if (ovf) begin
      d = 9'd0;
    end else begin
      d = {sign, mag};
    end
    return d;
  endfunction

endpackage

// File: rtl/mouse_packet_tracker_if.sv
// Byte stream from the PS/2 receiver and the cursor/button results.
interface mouse_packet_tracker_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [8:0] posX;
  logic [8:0] posY;
  logic [2:0] buttons;
  logic       packet_valid;
  logic       sync_error;

  modport master (
    output rx_data, rx_done,
    input  posX, posY, buttons, packet_valid, sync_error
  );

  modport slave (
    input  rx_data, rx_done,
    output posX, posY, buttons, packet_valid, sync_error
  );
endinterface

// File: rtl/axis_clamp.sv
// One cursor axis: applies a signed delta (added or subtracted) and
// saturates the result to 0..MAX. Purely combinational.
module axis_clamp #(
  parameter int MAX = 319
) (
  input  logic              [8:0] pos,
  input  logic signed       [8:0] delta,
  input  logic                    sub,
  output logic              [8:0] clamped
);

  localparam logic signed [10:0] MAX_S = 11'(MAX);
  localparam logic        [8:0]  MAX_U = 9'(MAX);

  logic signed [10:0] pos_ext_s;
  logic signed [10:0] delta_ext_s;
  logic signed [10:0] sum_s;

  // Widen to 11 bits so the sum can never wrap, then saturate.
  always_comb begin
    pos_ext_s   = $signed({2'b00, pos});
    delta_ext_s = $signed({{2{delta[8]}}, delta});
    if (sub) begin
      sum_s = pos_ext_s - delta_ext_s;
    end else begin
      sum_s = pos_ext_s + delta_ext_s;
    end
    if (sum_s[10]) begin
      clamped = 9'd0;
    end else if (sum_s > MAX_S) begin
      clamped = MAX_U;
    end else begin
      clamped = sum_s[8:0];
    end
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped absolute cursor
// position plus button state, resynchronising on bad byte0 or stalls.
module mouse_packet_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX          = 319,
  parameter int Y_MAX          = 239,
  parameter int X_INIT         = 160,
  parameter int Y_INIT         = 120,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  mouse_packet_tracker_if.slave bus
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_r, state_next_s;
  b0_t           b0_r;
  logic [7:0]    b1_r;
  logic [CW-1:0] cnt_r;

  logic       timeout_s;
  logic       latch_b0_s, latch_b1_s, commit_s, sync_err_s;
  logic [8:0] dx_s, dy_s, new_x_s, new_y_s;

  // Stall detect: only mid-packet, and a byte arriving this cycle wins.
  always_comb begin
    timeout_s = (state_r != WAIT_B0) && !bus.rx_done && (cnt_r == TO_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_B0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: advance per received byte, fall back to WAIT_B0 on stall.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_B0: begin
        if (bus.rx_done && bus.rx_data[SYNC_BIT]) state_next_s = WAIT_B1;
        else                                      state_next_s = WAIT_B0;
      end
      WAIT_B1: begin
        if (bus.rx_done)    state_next_s = WAIT_B2;
        else if (timeout_s) state_next_s = WAIT_B0;
        else                state_next_s = WAIT_B1;
      end
      WAIT_B2: begin
        if (bus.rx_done || timeout_s) state_next_s = WAIT_B0;
        else                          state_next_s = WAIT_B2;
      end
      default: state_next_s = WAIT_B0;
    endcase
  end

  // FSM actions: which byte to latch, when to commit, when to flag resync.
  always_comb begin
    latch_b0_s = 1'b0;
    latch_b1_s = 1'b0;
    commit_s   = 1'b0;
    sync_err_s = 1'b0;
    case (state_r)
      WAIT_B0: begin
        if (bus.rx_done) begin
          if (bus.rx_data[SYNC_BIT]) latch_b0_s = 1'b1;
          else                       sync_err_s = 1'b1;
        end else begin
          latch_b0_s = 1'b0;
        end
      end
      WAIT_B1: begin
        if (bus.rx_done)    latch_b1_s = 1'b1;
        else if (timeout_s) sync_err_s = 1'b1;
        else                latch_b1_s = 1'b0;
      end
      WAIT_B2: begin
        if (bus.rx_done)    commit_s   = 1'b1;
        else if (timeout_s) sync_err_s = 1'b1;
        else                commit_s   = 1'b0;
      end
      default: sync_err_s = 1'b0;
    endcase
  end

  // Inter-byte stall counter, idle while waiting for byte0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (state_r == WAIT_B0 || bus.rx_done || timeout_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Packet byte holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b0_r <= '0;
      b1_r <= 8'd0;
    end else begin
      if (latch_b0_s) begin
        b0_r.yovf  <= bus.rx_data[YOVF_BIT];
        b0_r.xovf  <= bus.rx_data[XOVF_BIT];
        b0_r.ysign <= bus.rx_data[YSIGN_BIT];
        b0_r.xsign <= bus.rx_data[XSIGN_BIT];
        b0_r.btn   <= bus.rx_data[2:0];
      end
      if (latch_b1_s) begin
        b1_r <= bus.rx_data;
      end
    end
  end

  // Movement deltas; byte2 is consumed straight from the receiver.
  always_comb begin
    dx_s = make_delta(b0_r.xsign, b0_r.xovf, b1_r);
    dy_s = make_delta(b0_r.ysign, b0_r.yovf, bus.rx_data);
  end

  axis_clamp #(.MAX(X_MAX)) u_clamp_x (
    .pos(bus.posX), .delta(dx_s), .sub(1'b0), .clamped(new_x_s)
  );

  // PS/2 +Y is up while screen Y grows downward, hence subtraction.
  axis_clamp #(.MAX(Y_MAX)) u_clamp_y (
    .pos(bus.posY), .delta(dy_s), .sub(1'b1), .clamped(new_y_s)
  );

  // Registered outputs: cursor/buttons update on commit, pulses last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.posX         <= 9'(X_INIT);
      bus.posY         <= 9'(Y_INIT);
      bus.buttons      <= 3'd0;
      bus.packet_valid <= 1'b0;
      bus.sync_error   <= 1'b0;
    end else begin
      bus.packet_valid <= commit_s;
      bus.sync_error   <= sync_err_s;
      if (commit_s) begin
        bus.posX    <= new_x_s;
        bus.posY    <= new_y_s;
        bus.buttons <= b0_r.btn;
      end
    end
  end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Directed bench for mouse_packet_tracker: a table of whole packets with
// hand-computed cursor results, plus sequences for resync, stall and reset.
module tb_mouse_packet_tracker;

  localparam int T = 16;

  logic clk;
  logic reset;
  mouse_packet_tracker_if bus ();

  mouse_packet_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sync_cnt = 0;
  int pv_cnt = 0;
  int overlap_cnt = 0;

  typedef struct {
    logic       do_reset;
    logic [7:0] b0, b1, b2;
    logic [8:0] ex, ey;
    logic [2:0] eb;
  } vec_t;

  vec_t vecs [11];

  // Pulse monitor, sampled well away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (bus.sync_error) sync_cnt++;
    if (bus.packet_valid) pv_cnt++;
    if (bus.sync_error && bus.packet_valid) overlap_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_packet(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [8:0] ex,
                             input logic [8:0] ey, input logic [2:0] eb);
    send_byte(b0);
    chk({nm, " pv_early"}, 32'(bus.packet_valid), 32'd0);
    send_byte(b1);
    send_byte(b2);
    chk({nm, " pv"},    32'(bus.packet_valid), 32'd1);
    chk({nm, " sync"},  32'(bus.sync_error),   32'd0);
    chk({nm, " posX"},  32'(bus.posX),         32'(ex));
    chk({nm, " posY"},  32'(bus.posY),         32'(ey));
    chk({nm, " btn"},   32'(bus.buttons),      32'(eb));
    @(negedge clk);
    chk({nm, " pv_end"}, 32'(bus.packet_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int hit;

    //            rst   b0     b1     b2     X       Y       btn
    vecs[0]  = '{1'b1, 8'h08, 8'h05, 8'h03, 9'd165, 9'd117, 3'd0};
    vecs[1]  = '{1'b1, 8'h18, 8'h00, 8'h00, 9'd0,   9'd120, 3'd0};
    vecs[2]  = '{1'b0, 8'h09, 8'hFF, 8'h00, 9'd255, 9'd120, 3'd1};
    vecs[3]  = '{1'b0, 8'h08, 8'hFF, 8'h00, 9'd319, 9'd120, 3'd0};
    vecs[4]  = '{1'b0, 8'h28, 8'h00, 8'h00, 9'd319, 9'd239, 3'd0};
    vecs[5]  = '{1'b0, 8'h08, 8'h00, 8'h7F, 9'd319, 9'd112, 3'd0};
    vecs[6]  = '{1'b1, 8'h48, 8'h7F, 8'h00, 9'd160, 9'd120, 3'd0};
    vecs[7]  = '{1'b0, 8'h0A, 8'h00, 8'h00, 9'd160, 9'd120, 3'd2};
    vecs[8]  = '{1'b0, 8'h88, 8'h00, 8'h80, 9'd160, 9'd120, 3'd0};
    vecs[9]  = '{1'b0, 8'h0F, 8'h80, 8'hFF, 9'd288, 9'd0,   3'd7};
    vecs[10] = '{1'b0, 8'h38, 8'h01, 8'h01, 9'd33,  9'd239, 3'd0};

    reset = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst posX", 32'(bus.posX), 32'd160);
    chk("rst posY", 32'(bus.posY), 32'd120);
    chk("rst btn",  32'(bus.buttons), 32'd0);
    chk("rst pv",   32'(bus.packet_valid), 32'd0);
    chk("rst sync", 32'(bus.sync_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_reset) do_reset();
      send_packet($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2,
                  vecs[i].ex, vecs[i].ey, vecs[i].eb);
    end

    // Bad byte0 is dropped with a single sync_error pulse.
    do_reset();
    s0 = sync_cnt;
    send_byte(8'h07);
    chk("bad_b0 sync", 32'(bus.sync_error), 32'd1);
    chk("bad_b0 pv",   32'(bus.packet_valid), 32'd0);
    @(negedge clk);
    chk("bad_b0 sync_end", 32'(bus.sync_error), 32'd0);
    send_packet("resync", 8'h08, 8'h02, 8'h02, 9'd162, 9'd118, 3'd0);
    chk("bad_b0 count", 32'(sync_cnt - s0), 32'd1);

    // Stall after byte1 times out on exactly the T-th idle cycle.
    do_reset();
    send_byte(8'h08);
    send_byte(8'h01);
    hit = 0;
    for (int i = 1; i <= T + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.sync_error) begin
        hit = i;
        break;
      end
    end
    chk("timeout cycle", 32'(hit), 32'(T));
    @(negedge clk);
    @(negedge clk);
    chk("timeout sync_end", 32'(bus.sync_error), 32'd0);
    send_packet("after_to", 8'h08, 8'h04, 8'h00, 9'd164, 9'd120, 3'd0);

    // A byte arriving on the last allowed cycle beats the timeout.
    do_reset();
    s0 = sync_cnt;
    send_byte(8'h08);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h03);
    send_byte(8'h00);
    chk("late_b1 pv",   32'(bus.packet_valid), 32'd1);
    chk("late_b1 posX", 32'(bus.posX), 32'd163);
    @(negedge clk);
    chk("late_b1 nosync", 32'(sync_cnt - s0), 32'd0);

    // Reset mid-packet restores the home position and drops partial bytes.
    do_reset();
    send_packet("pre_rst", 8'h08, 8'h05, 8'h00, 9'd165, 9'd120, 3'd0);
    send_byte(8'h08);
    send_byte(8'h01);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst posX", 32'(bus.posX), 32'd160);
    chk("mid_rst posY", 32'(bus.posY), 32'd120);
    reset = 1'b1;
    @(negedge clk);
    send_packet("post_rst", 8'h08, 8'h01, 8'h01, 9'd161, 9'd119, 3'd0);

    repeat (2) @(negedge clk);
    chk("pulse overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
